// File: rtl/hs32_pkg.sv
// rtl/hs32_pkg.sv - packet and hazard types shared by the hs32 execute stage
package hs32_pkg;

    typedef struct packed {
        logic       neg;
        logic       sub;
        logic       cen;
        logic [1:0] opr;
        logic       fwe;
    } hs32_ctl;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        hs32_ctl     ctl;
        logic [3:0]  rd;
        logic        we1;
        logic        isldr;
        logic        isstr;
        logic        fwd;
        logic        fwd2;
        logic        xud;
    } hs32_s2pkt;

    typedef struct packed {
        logic       vld;
        logic [3:0] rd;
        logic       lsu;
    } hs32_stall;

endpackage

// File: rtl/hs32_execute.sv
// rtl/hs32_execute.sv - hs32 S3 execute stage: ALU, flags, result/store registers
// Optional iterative multiplier compiled in with HS32_EXEC_MUL_EN.
module hs32_execute
    import hs32_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_i,
    input  hs32_s2pkt   data_i,
    input  logic [31:0] wb_data_i,
    input  logic        mul_i,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [31:0] res_o,
    output logic [31:0] sdata_o,
    output logic [3:0]  rd_o,
    output logic        we_o,
    output logic        isldr_o,
    output logic        isstr_o,
    output logic [31:0] fwd_o,
    output logic [3:0]  flags_o,
    output hs32_stall   s3_o,
    output logic        stall_o
);

    logic        r_valid;
    logic [31:0] r_res;
    logic [31:0] r_sdata;
    logic [3:0]  r_rd;
    logic        r_we;
    logic        r_isldr;
    logic        r_isstr;
    logic [3:0]  r_flags;

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_bn;
    logic        w_cin;
    logic [32:0] w_sum;
    logic [31:0] w_res;
    logic        w_v;
    logic        w_accept;
    logic        w_busy;
    logic        w_mul_go;
    logic        w_mul_done;
    logic [31:0] w_mul_res;
    logic [3:0]  w_mul_rd;
    logic        w_mul_we;
    logic        w_mul_ldr;
    logic        w_mul_str;
    logic        w_mul_fwe;
    logic        w_unused;

    // flags_o is {N,Z,C,V}; carry chain input comes from the live C flag
    always_comb begin
        w_a   = data_i.fwd  ? r_res     : data_i.d1;
        w_b   = data_i.fwd2 ? wb_data_i : data_i.d2;
        w_bn  = data_i.ctl.neg ? ~w_b : w_b;
        w_cin = data_i.ctl.cen ? r_flags[1] : data_i.ctl.sub;
        w_sum = {1'b0, w_a} + {1'b0, w_bn} + {32'd0, w_cin};
        w_v   = (w_a[31] == w_bn[31]) && (w_sum[31] != w_a[31]);
        case (data_i.ctl.opr)
            2'd0:    w_res = w_sum[31:0];
            2'd1:    w_res = w_a & w_bn;
            2'd2:    w_res = w_a | w_bn;
            default: w_res = w_a ^ w_bn;
        endcase
    end

    assign stall_o  = stall_i | w_busy;
    assign w_accept = valid_i & ~stall_o;

`ifdef HS32_EXEC_MUL_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_ma;
    logic [31:0] r_mb;
    logic [31:0] r_acc;
    logic [5:0]  r_cnt;
    logic [3:0]  r_mrd;
    logic        r_mwe;
    logic        r_mldr;
    logic        r_mstr;
    logic        r_mfwe;

    assign w_busy     = (r_state != S_IDLE);
    assign w_mul_go   = w_accept & mul_i;
    assign w_mul_done = (r_state == S_DONE);
    assign w_mul_res  = r_acc;
    assign w_mul_rd   = r_mrd;
    assign w_mul_we   = r_mwe;
    assign w_mul_ldr  = r_mldr;
    assign w_mul_str  = r_mstr;
    assign w_mul_fwe  = r_mfwe;

    // One extra MUL cycle with r_cnt==32 gives the fixed 34-cycle latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ma    <= 32'd0;
            r_mb    <= 32'd0;
            r_acc   <= 32'd0;
            r_cnt   <= 6'd0;
            r_mrd   <= 4'd0;
            r_mwe   <= 1'b0;
            r_mldr  <= 1'b0;
            r_mstr  <= 1'b0;
            r_mfwe  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mul_go) begin
                        r_state <= S_MUL;
                        r_ma    <= w_a;
                        r_mb    <= w_b;
                        r_acc   <= 32'd0;
                        r_cnt   <= 6'd0;
                        r_mrd   <= data_i.rd;
                        r_mwe   <= data_i.we1;
                        r_mldr  <= data_i.isldr;
                        r_mstr  <= data_i.isstr;
                        r_mfwe  <= data_i.ctl.fwe;
                    end
                end
                S_MUL: begin
                    if (r_cnt == 6'd32) begin
                        r_state <= S_DONE;
                    end else begin
                        if (r_mb[0]) r_acc <= r_acc + r_ma;
                        r_ma  <= r_ma << 1;
                        r_mb  <= r_mb >> 1;
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_DONE: begin
                    if (!stall_i) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign w_busy     = 1'b0;
    assign w_mul_go   = 1'b0;
    assign w_mul_done = 1'b0;
    assign w_mul_res  = 32'd0;
    assign w_mul_rd   = 4'd0;
    assign w_mul_we   = 1'b0;
    assign w_mul_ldr  = 1'b0;
    assign w_mul_str  = 1'b0;
    assign w_mul_fwe  = 1'b0;
`endif

    assign w_unused = &{1'b0, data_i.xud, mul_i};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_res   <= 32'd0;
            r_sdata <= 32'd0;
            r_rd    <= 4'd0;
            r_we    <= 1'b0;
            r_isldr <= 1'b0;
            r_isstr <= 1'b0;
            r_flags <= 4'd0;
        end else if (!stall_i) begin
            if (w_mul_done) begin
                r_valid <= 1'b1;
                r_res   <= w_mul_res;
                r_rd    <= w_mul_rd;
                r_we    <= w_mul_we;
                r_isldr <= w_mul_ldr;
                r_isstr <= w_mul_str;
                if (w_mul_fwe) begin
                    r_flags[3] <= w_mul_res[31];
                    r_flags[2] <= (w_mul_res == 32'd0);
                end
            end else if (w_accept && !w_mul_go) begin
                r_valid <= 1'b1;
                r_res   <= w_res;
                r_sdata <= w_b;
                r_rd    <= data_i.rd;
                r_we    <= data_i.we1;
                r_isldr <= data_i.isldr;
                r_isstr <= data_i.isstr;
                if (data_i.ctl.fwe) begin
                    r_flags[3] <= w_res[31];
                    r_flags[2] <= (w_res == 32'd0);
                    if (data_i.ctl.opr == 2'd0) begin
                        r_flags[1] <= w_sum[32];
                        r_flags[0] <= w_v;
                    end
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid_o  = r_valid;
    assign res_o    = r_res;
    assign fwd_o    = r_res;
    assign sdata_o  = r_sdata;
    assign rd_o     = r_rd;
    assign we_o     = r_we;
    assign isldr_o  = r_isldr;
    assign isstr_o  = r_isstr;
    assign flags_o  = r_flags;
    assign s3_o.vld = r_valid & r_we;
    assign s3_o.rd  = r_rd;
    assign s3_o.lsu = r_isldr;

endmodule

// File: tb/tb_hs32_execute.sv
// tb/tb_hs32_execute.sv - randomized self-checking bench for hs32_execute against a behavioural model
module tb_hs32_execute;
    import hs32_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_i;
    hs32_s2pkt   data_i;
    logic [31:0] wb_data_i;
    logic        mul_i;
    logic        stall_i;
    logic        valid_o;
    logic [31:0] res_o;
    logic [31:0] sdata_o;
    logic [3:0]  rd_o;
    logic        we_o;
    logic        isldr_o;
    logic        isstr_o;
    logic [31:0] fwd_o;
    logic [3:0]  flags_o;
    hs32_stall   s3_o;
    logic        stall_o;

    int total = 0;
    int bad   = 0;

    logic        m_valid;
    logic [31:0] m_res;
    logic [31:0] m_sdata;
    logic [3:0]  m_rd;
    logic        m_we;
    logic        m_ldr;
    logic        m_str;
    logic [3:0]  m_flags;

    always #5 clk = ~clk;

    hs32_execute dut (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .data_i(data_i),
        .wb_data_i(wb_data_i), .mul_i(mul_i), .stall_i(stall_i),
        .valid_o(valid_o), .res_o(res_o), .sdata_o(sdata_o), .rd_o(rd_o),
        .we_o(we_o), .isldr_o(isldr_o), .isstr_o(isstr_o), .fwd_o(fwd_o),
        .flags_o(flags_o), .s3_o(s3_o), .stall_o(stall_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_res = 0; m_sdata = 0; m_rd = 0;
        m_we = 0; m_ldr = 0; m_str = 0; m_flags = 0;
    endtask

    // Expected next state from the current inputs, using wide integer arithmetic
    task automatic model_step();
        logic [31:0] a, b, bn, r;
        logic        cin;
        longint unsigned us;
        longint          ss;
        if (stall_i) return;
        if (!valid_i) begin
            m_valid = 0;
            return;
        end
        a   = data_i.fwd  ? m_res     : data_i.d1;
        b   = data_i.fwd2 ? wb_data_i : data_i.d2;
        bn  = data_i.ctl.neg ? ~b : b;
        cin = data_i.ctl.cen ? m_flags[1] : data_i.ctl.sub;
        us  = 64'(a) + 64'(bn) + 64'(cin);
        ss  = longint'($signed(a)) + longint'($signed(bn)) + longint'(cin);
        case (data_i.ctl.opr)
            2'd0:    r = us[31:0];
            2'd1:    r = a & bn;
            2'd2:    r = a | bn;
            default: r = a ^ bn;
        endcase
        if (data_i.ctl.fwe) begin
            m_flags[3] = r[31];
            m_flags[2] = (r == 0);
            if (data_i.ctl.opr == 2'd0) begin
                m_flags[1] = us[32];
                m_flags[0] = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
        end
        m_valid = 1; m_res = r; m_sdata = b; m_rd = data_i.rd;
        m_we = data_i.we1; m_ldr = data_i.isldr; m_str = data_i.isstr;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
        check({tag, ".res"},   res_o,        m_res);
        check({tag, ".fwd"},   fwd_o,        m_res);
        check({tag, ".sdata"}, sdata_o,      m_sdata);
        check({tag, ".rd"},    32'(rd_o),    32'(m_rd));
        check({tag, ".we"},    32'(we_o),    32'(m_we));
        check({tag, ".ldr"},   32'(isldr_o), 32'(m_ldr));
        check({tag, ".str"},   32'(isstr_o), 32'(m_str));
        check({tag, ".flags"}, 32'(flags_o), 32'(m_flags));
        check({tag, ".s3"},    32'(s3_o),    32'({m_valid & m_we, m_rd, m_ldr}));
    endtask

    task automatic set_pkt(input logic [31:0] d1, input logic [31:0] d2, input logic neg,
                           input logic sub, input logic cen, input logic [1:0] opr,
                           input logic fwe, input logic fwd, input logic fwd2);
        data_i         = '0;
        data_i.d1      = d1;
        data_i.d2      = d2;
        data_i.ctl.neg = neg;
        data_i.ctl.sub = sub;
        data_i.ctl.cen = cen;
        data_i.ctl.opr = opr;
        data_i.ctl.fwe = fwe;
        data_i.fwd     = fwd;
        data_i.fwd2    = fwd2;
        data_i.rd      = 4'd5;
        data_i.we1     = 1'b1;
    endtask

    // Inputs already driven at a negedge: update model, cross the edge, compare at next negedge
    task automatic step(input string tag);
        #1;
        check({tag, ".stall_o"}, 32'(stall_o), 32'(stall_i));
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic do_reset();
        reset_n = 0; valid_i = 0; stall_i = 0; mul_i = 0; wb_data_i = 0; data_i = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all("reset");
        check("reset.stall_o", 32'(stall_o), 32'd0);
        reset_n = 1;
    endtask

    initial begin
        do_reset();

        valid_i = 1;
        set_pkt(32'h7FFF_FFFF, 32'd1, 0, 0, 0, 2'd0, 1, 0, 0);
        step("add_ovf");
        check("add_ovf.res_k", res_o, 32'h8000_0000);
        check("add_ovf.nzcv_k", 32'(flags_o), 32'b1001);

        set_pkt(32'd5, 32'd5, 1, 1, 0, 2'd0, 1, 0, 0);
        step("sub_eq");
        check("sub_eq.res_k", res_o, 32'd0);
        check("sub_eq.nzcv_k", 32'(flags_o), 32'b0110);

        set_pkt(32'h10, 32'd0, 0, 0, 0, 2'd0, 0, 0, 0);
        step("dep1");
        set_pkt(32'hDEAD, 32'h20, 0, 0, 0, 2'd0, 0, 1, 0);
        step("dep2");
        check("dep2.res_k", res_o, 32'h30);
        check("dep2.valid_k", 32'(valid_o), 32'd1);

        set_pkt(32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 0, 2'd1, 1, 0, 1);
        wb_data_i = 32'hFFFF_0000;
        stall_i = 1;
        for (int i = 0; i < 3; i++) step("stall3");
        check("stall3.res_k", res_o, 32'h30);
        stall_i = 0;
        step("unstall");
        check("unstall.res_k", res_o, 32'hF0F0_0000);

        valid_i = 0;
        step("bubble");
        check("bubble.valid_k", 32'(valid_o), 32'd0);

        for (int n = 0; n < 400; n++) begin
            valid_i   = ($urandom_range(0, 3) != 0);
            stall_i   = ($urandom_range(0, 4) == 0);
            wb_data_i = $urandom;
            data_i    = hs32_s2pkt'({$urandom, $urandom, $urandom});
            if ($urandom_range(0, 3) == 0) data_i.d2 = data_i.d1;
            if ($urandom_range(0, 5) == 0) data_i.d1 = 32'h7FFF_FFFF;
            step("rand");
        end

`ifdef HS32_EXEC_MUL_EN
        begin
            int n;
            stall_i = 0;
            valid_i = 1;
            mul_i   = 1;
            set_pkt(32'h1234_5678, 32'h10, 0, 0, 0, 2'd0, 1, 0, 0);
            data_i.rd = 4'd3;
            @(posedge clk);
            @(negedge clk);
            valid_i = 0;
            mul_i   = 0;
            n = 1;
            while (!valid_o && n < 100) begin
                check("mul.stall_o", 32'(stall_o), 32'd1);
                @(posedge clk);
                @(negedge clk);
                n++;
            end
            check("mul.latency", 32'(n), 32'd34);
            check("mul.res", res_o, 32'h2345_6780);
            check("mul.rd", 32'(rd_o), 32'd3);

            valid_i = 1;
            mul_i   = 1;
            @(posedge clk);
            @(negedge clk);
            valid_i = 0;
            mul_i   = 0;
            repeat (10) @(negedge clk);
            check("mulrst.stall_pre", 32'(stall_o), 32'd1);
            do_reset();
            valid_i = 1;
            set_pkt(32'd7, 32'd8, 0, 0, 0, 2'd0, 1, 0, 0);
            step("post_mul");
            check("post_mul.res_k", res_o, 32'd15);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hs32_execute.md
HS32_EXECUTE -- requirements
Module: hs32_execute

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports valid_i (input, 1, S2 packet valid) and data_i (input, hs32_s2pkt, fields d1, d2, ctl{neg,sub,cen,opr,fwe}, rd, we1, isldr, isstr, fwd, fwd2, xud).
REQ-004 SHALL have port wb_data_i, input, 32, writeback-stage result, selected for d2 when data_i.fwd2=1.
REQ-005 SHALL have port mul_i, input, 1, S2 packet is a multiply (effective only with HS32_EXEC_MUL_EN).
REQ-006 SHALL have port stall_i, input, 1, downstream (memory stage) hold request.
REQ-007 SHALL have outputs valid_o (1), res_o (32, result), sdata_o (32, store data), rd_o (4), we_o (1), isldr_o (1), isstr_o (1), all registered.
REQ-008 SHALL have outputs fwd_o (32, equal to res_o, feeds decode2 fwd_i) and flags_o (4, {N,Z,C,V}, registered).
REQ-009 SHALL have output s3_o, hs32_stall: vld=valid_o&we_o, rd=rd_o, lsu=isldr_o.
REQ-010 SHALL have output stall_o, 1, asserted when the block cannot accept a new S2 packet this cycle.

Function
REQ-011 Operand A SHALL be res_o when data_i.fwd=1, else data_i.d1; operand B SHALL be wb_data_i when data_i.fwd2=1, else data_i.d2.
REQ-012 B' SHALL be ~B when ctl.neg=1, else B.
REQ-013 Carry-in SHALL be C flag when ctl.cen=1, else ctl.sub.
REQ-014 opr SHALL select: 0 = A+B'+cin (33-bit, carry = bit 32), 1 = A&B', 2 = A|B', 3 = A^B'.
REQ-015 Accept = valid_i & ~stall_o; on accept, res_o/rd_o/we_o(=data_i.we1)/isldr_o/isstr_o/sdata_o(=B) SHALL load and valid_o SHALL be 1 at next edge (1-cycle latency for non-multiply ops).
REQ-016 When stall_i=1, all output registers and flags SHALL hold, and stall_o SHALL be 1.
REQ-017 When stall_i=0 and no accept, valid_o SHALL go 0 next edge (bubble); other outputs hold.
REQ-018 On accept with ctl.fwe=1: N=res[31], Z=(res==0); C and V update only for opr=0 (V = signed overflow of A+B'+cin); for opr!=0 C,V hold.
REQ-019 Back-to-back dependent ops SHALL work via REQ-011: forwarded A uses res_o value present in the accept cycle.
REQ-020 valid_i with stall_i=1 simultaneously SHALL NOT be accepted; upstream holds packet.

Reset
REQ-021 On reset_n=0 (any time, including mid-multiply): valid_o=0, res_o=0, sdata_o=0, rd_o=0, we_o=0, isldr_o=0, isstr_o=0, flags_o=0, FSM=IDLE, stall_o=0, s3_o.vld=0.
REQ-022 First accept SHALL be possible on the first rising edge after reset_n deasserts.

Configuration
REQ-023 Macro HS32_EXEC_MUL_EN SHALL compile in an iterative multiplier; without it mul_i is ignored and the packet executes per REQ-014.
REQ-024 With HS32_EXEC_MUL_EN: FSM states IDLE, MUL, DONE; accept with mul_i=1 moves IDLE->MUL, latching A, B (unnegated), 6-bit counter=0, accumulator=0.
REQ-025 In MUL: one shift-add step per cycle on low 32 bits of A*B; counter increments; after 32 steps -> DONE; stall_o=1 in MUL and DONE; valid_o=0 during MUL.
REQ-026 DONE -> IDLE when stall_i=0: res_o=product[31:0], valid_o=1, rd_o/we_o loaded from latched packet; flags N,Z update if fwe, C,V hold; multiply latency 34 cycles accept-to-valid_o.
REQ-027 stall_i=1 in DONE SHALL hold DONE; in MUL it SHALL NOT pause iteration.

Verification
REQ-028 Add: d1=0x7FFFFFFF, d2=1, opr=0, fwe=1 -> res_o=0x80000000 next cycle, flags N=1 Z=0 C=0 V=1.
REQ-029 Sub: d1=5, d2=5, neg=1, sub=1, fwe=1 -> res_o=0, Z=1, C=1, V=0.
REQ-030 Dependency: op1 res=0x10, op2 fwd=1 d2=0x20 add back-to-back -> op2 res_o=0x30, no bubble.
REQ-031 stall_i held 3 cycles with valid_i=1 -> outputs and flags frozen, stall_o=1, packet accepted on first cycle stall_i=0.
REQ-032 MUL_EN: 0x12345678 * 0x10 -> res_o=0x23456780 exactly 34 cycles after accept, stall_o=1 throughout; reset_n pulsed mid-MUL -> REQ-021 state, next op normal.
